// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types and constants for the data-memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Responder FSM states, explicitly encoded
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Byte-offset bits below the word index in a byte address
    localparam int c_WORD_OFF_BITS = 2;

    // Latency counter width; covers the full 1..255 latency range
    localparam int c_CNT_W = 8;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_array
//  Description : Single-port word storage, synchronous write, combinational
//                read. Contents are never reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_array #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] index,
    input  logic [DATA_W-1:0]              wdata,
    output logic [DATA_W-1:0]              rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

    // Write port: commit the word on the clock edge when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[index] <= wdata;
        end
    end

    assign rdata = r_mem[index];

endmodule : dmem_array
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Multi-cycle data-memory responder. Accepts one load/store
//                over valid/ready, waits LATENCY cycles, then presents a
//                registered response held until the requester takes it.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int               c_IDX_W    = $clog2(DEPTH_WORDS);
    // Counter starts at LATENCY-1 and the access happens on the edge where it
    // has reached zero, so accept at edge N gives resp_valid after edge N+LATENCY.
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_write;
    logic                r_misalign;
    logic [c_IDX_W-1:0]  r_index;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;

    logic                w_accept;
    logic                w_access;
    logic                w_resp_done;
    logic                w_mem_we;
    logic [DATA_W-1:0]   w_mem_rdata;
    logic                w_unused_addr;

    // Only the word-index and byte-offset bits matter; the rest wrap silently
    assign w_unused_addr = ^{1'b0, req_addr};

    assign w_accept    = req_valid && (r_state == IDLE);
    assign w_access    = (r_state == WAIT) && (r_count == '0);
    assign w_resp_done = (r_state == RESP) && resp_ready;
    // Misaligned requests never touch storage; reset blocks a pending commit
    assign w_mem_we    = w_access && r_write && !r_misalign && !reset;

    dmem_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .we    (w_mem_we),
        .index (r_index),
        .wdata (r_wdata),
        .rdata (w_mem_rdata)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: every request waits in WAIT until the counter expires
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (req_valid)       w_state_next = WAIT;
            WAIT:    if (r_count == '0)   w_state_next = RESP;
            RESP:    if (resp_ready)      w_state_next = IDLE;
            default:                      w_state_next = IDLE;
        endcase
    end

    // Handshake outputs decode straight from the state register (no resp_ready path)
    always_comb begin
        req_ready  = (r_state == IDLE);
        resp_valid = (r_state == RESP);
    end

    // Request latches, latency counter and response data registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count    <= '0;
            r_write    <= 1'b0;
            r_misalign <= 1'b0;
            r_index    <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_count    <= c_CNT_LOAD;
                r_write    <= req_write;
                r_misalign <= (req_addr[c_WORD_OFF_BITS-1:0] != '0);
                r_index    <= req_addr[c_WORD_OFF_BITS +: c_IDX_W];
                r_wdata    <= req_wdata;
            end else if ((r_state == WAIT) && (r_count != '0)) begin
                r_count <= r_count - 1'b1;
            end

            if (w_access) begin
                r_err   <= r_misalign;
                r_rdata <= (r_write || r_misalign) ? '0 : w_mem_rdata;
            end else if (w_resp_done) begin
                r_err   <= 1'b0;
                r_rdata <= '0;
            end
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder. Instance 0 is built
//                with LATENCY=4, instance 1 with LATENCY=1. A word-level
//                reference model predicts load data, error flags, latency
//                and throughput.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam int c_DEPTH = 1024;
    localparam int c_LAT [2] = '{4, 1};

    logic        clk;
    logic        reset;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_write  [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    int          checks;
    int          errors;
    int          cyc;
    int          acc_cyc [2];
    logic [31:0] mdl [2][c_DEPTH];

    dmem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(c_DEPTH), .LATENCY(4)) u_dut0 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid[0]),
        .req_ready  (req_ready[0]),
        .req_write  (req_write[0]),
        .req_addr   (req_addr[0]),
        .req_wdata  (req_wdata[0]),
        .resp_valid (resp_valid[0]),
        .resp_ready (resp_ready[0]),
        .resp_rdata (resp_rdata[0]),
        .resp_err   (resp_err[0])
    );

    dmem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(c_DEPTH), .LATENCY(1)) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid[1]),
        .req_ready  (req_ready[1]),
        .req_write  (req_write[1]),
        .req_addr   (req_addr[1]),
        .req_wdata  (req_wdata[1]),
        .resp_valid (resp_valid[1]),
        .resp_ready (resp_ready[1]),
        .resp_rdata (resp_rdata[1]),
        .resp_err   (resp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction; hold = cycles the response is refused before taking it.
    // With inject set, a stray request is presented while the response is held.
    task automatic do_req(input int d, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold, input bit inject);
        int          idx;
        int          lat;
        bit          exp_err;
        logic [31:0] exp_rd;
        idx     = int'((addr >> 2) % c_DEPTH);
        exp_err = (addr[1:0] != 2'b00);
        exp_rd  = (wr || exp_err) ? 32'h0 : mdl[d][idx];
        if (wr && !exp_err) mdl[d][idx] = wdata;

        check($sformatf("d%0d req_ready before accept", d), 32'(req_ready[d]), 32'd1);
        req_valid[d]  = 1'b1;
        req_write[d]  = wr;
        req_addr[d]   = addr;
        req_wdata[d]  = wdata;
        resp_ready[d] = (hold == 0);
        @(posedge clk); #1;
        acc_cyc[d]   = cyc;
        req_valid[d] = 1'b0;
        req_wdata[d] = $urandom;

        lat = 0;
        while (resp_valid[d] !== 1'b1 && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("d%0d latency addr=%0h", d, addr), 32'(lat), 32'(c_LAT[d]));
        check($sformatf("d%0d rdata addr=%0h", d, addr), resp_rdata[d], exp_rd);
        check($sformatf("d%0d err addr=%0h", d, addr), 32'(resp_err[d]), 32'(exp_err));

        for (int i = 0; i < hold; i++) begin
            if (inject) begin
                req_valid[d] = 1'b1;
                req_write[d] = 1'b1;
                req_addr[d]  = 32'h10;
                req_wdata[d] = 32'h0BAD_0BAD;
            end
            @(posedge clk); #1;
            check($sformatf("d%0d held valid", d), 32'(resp_valid[d]), 32'd1);
            check($sformatf("d%0d held rdata", d), resp_rdata[d], exp_rd);
            check($sformatf("d%0d held err", d), 32'(resp_err[d]), 32'(exp_err));
            check($sformatf("d%0d held req_ready", d), 32'(req_ready[d]), 32'd0);
        end
        req_valid[d]  = 1'b0;
        resp_ready[d] = 1'b1;
        @(posedge clk); #1;
        check($sformatf("d%0d resp_valid after take", d), 32'(resp_valid[d]), 32'd0);
        check($sformatf("d%0d req_ready after take", d), 32'(req_ready[d]), 32'd1);
    endtask

    initial begin
        int          prev_acc;
        logic [31:0] a;
        bit          wr;
        checks = 0;
        errors = 0;
        cyc    = 0;
        reset  = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d]  = 1'b0;
            req_write[d]  = 1'b0;
            req_addr[d]   = '0;
            req_wdata[d]  = '0;
            resp_ready[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d reset req_ready", d), 32'(req_ready[d]), 32'd1);
            check($sformatf("d%0d reset resp_valid", d), 32'(resp_valid[d]), 32'd0);
            check($sformatf("d%0d reset rdata", d), resp_rdata[d], 32'd0);
            check($sformatf("d%0d reset err", d), 32'(resp_err[d]), 32'd0);
        end
        reset = 1'b0;
        @(posedge clk); #1;

        // Store then load back
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0);
        do_req(0, 1'b0, 32'h10, 32'h0, 0, 1'b0);

        // Response refused for 10 cycles, stray request ignored, then reload
        do_req(0, 1'b0, 32'h10, 32'h0, 10, 1'b1);
        repeat (3) begin
            @(posedge clk); #1;
            check("d0 no response to stray request", 32'(resp_valid[0]), 32'd0);
        end
        do_req(0, 1'b0, 32'h10, 32'h0, 0, 1'b0);

        // Misaligned load, storage untouched
        do_req(0, 1'b0, 32'h13, 32'h0, 0, 1'b0);
        do_req(0, 1'b1, 32'h12, 32'h7777_7777, 0, 1'b0);
        do_req(0, 1'b0, 32'h10, 32'h0, 0, 1'b0);

        // Index wrap on high address bits
        do_req(0, 1'b1, 32'h1004, 32'h5A5A5A5A, 0, 1'b0);
        do_req(0, 1'b0, 32'h0004, 32'h0, 0, 1'b0);

        // Reset while a store is waiting drops the store
        do_req(0, 1'b1, 32'h20, 32'hCAFEF00D, 0, 1'b0);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h20;
        req_wdata[0] = 32'h11111111;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("reset-in-wait req_ready", 32'(req_ready[0]), 32'd1);
        check("reset-in-wait resp_valid", 32'(resp_valid[0]), 32'd0);
        check("reset-in-wait rdata", resp_rdata[0], 32'd0);
        check("reset-in-wait err", 32'(resp_err[0]), 32'd0);
        @(posedge clk);
        @(posedge clk); #3;
        reset = 1'b0;
        @(posedge clk); #1;
        do_req(0, 1'b0, 32'h20, 32'h0, 0, 1'b0);

        // Preload words 0..15 in both instances so every random load is defined
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                do_req(d, 1'b1, 32'(i << 2), $urandom, 0, 1'b0);
            end
        end

        // Random stream; instance 1 runs back-to-back and its throughput is checked
        for (int d = 0; d < 2; d++) begin
            prev_acc = -1;
            for (int n = 0; n < 40; n++) begin
                wr = 1'($urandom_range(0, 1));
                a  = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 15)) << 2);
                if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
                do_req(d, wr, a, $urandom, (d == 0) ? int'($urandom_range(0, 3)) : 0, 1'b0);
                if (d == 1 && prev_acc >= 0) begin
                    check("d1 request period", 32'(acc_cyc[1] - prev_acc), 32'(c_LAT[1] + 2));
                end
                prev_acc = acc_cyc[d];
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_dmem_responder
`default_nettype wire
